dtcm_lsu: RTL and testbench
===========================

// Module: dtcm_lsu
// PURPOSE
//  Load/store unit that initiates all accesses to the 1R1W word-wide data memory (dtcm).
//  Sits between the core MEM stage and the memory. Serializes one request at a time.
//  Sub-word stores use read-modify-write, because the memory has no byte enables.
//  Loads are sign- or zero-extended per RV32I funct3.
// PARAMETERS
//  AW  4   memory word-address width; byte address uses ADDR[AW+1:0]
//  DW  32  data width; only 32 is supported
// PORTS
//  CLK      in   1   single clock for the LSU and the memory (WCLK=RCLK=CLK)
//  RST      in   1   synchronous, active-high reset
//  REQ      in   1   access request; held with stable fields until DONE
//  WE       in   1   1=store, 0=load
//  FUNCT3   in   3   000 B, 001 H, 010 W, 100 BU, 101 HU
//  ADDR     in   32  byte address; bits above AW+1 are ignored
//  WDATA    in   DW  store data, right-aligned
//  BUSY     out  1   high in any state other than IDLE
//  DONE     out  1   one-cycle pulse; request complete
//  ERR      out  1   one-cycle pulse with DONE; request rejected
//  RDATA    out  DW  extended load result; valid while DONE is high, held until the next load
//  M_WADDR  out  AW  memory write word address
//  M_WDATA  out  DW  memory write data
//  M_WEN    out  1   memory write enable
//  M_RADDR  out  AW  memory read word address
//  M_REN    out  1   memory read enable
//  M_RDATA  in   DW  memory read data; valid the cycle after M_REN
// BEHAVIOUR
//  Reset: state=IDLE; DONE=ERR=0; RDATA=0; M_WEN=M_REN=0 during any RST cycle.
//  FSM states: IDLE, LD_WAIT, RMW_WR, RESP.
//  Requests are accepted only in IDLE when REQ=1. Address, FUNCT3, WE, WDATA and offset are
//   latched at acceptance.
//  In IDLE, memory outputs decode combinationally from the request; in other states they
//   decode from the latched request.
//  Load:    IDLE (M_REN=1) -> LD_WAIT (extract lane from M_RDATA, extend, register RDATA,
//           DONE<=1) -> IDLE. DONE is high 2 cycles after acceptance.
//  SW:      IDLE (M_WEN=1, M_WDATA=WDATA) -> RESP (DONE=1) -> IDLE.
//           The write is committed at the end of the acceptance cycle.
//  SB/SH:   IDLE (M_REN=1) -> RMW_WR (M_WEN=1, M_WDATA=M_RDATA with the lane replaced)
//           -> RESP (DONE=1) -> IDLE.
//  Byte lanes: ADDR[1:0] selects the byte; ADDR[1] selects the half (little-endian).
//  Extension: B/H are sign-extended from the top bit of the lane; BU/HU are zero-extended.
//  Invalid FUNCT3 (011, 110, 111): no memory access; IDLE -> RESP with DONE=ERR=1.
//  BUSY=1 in LD_WAIT, RMW_WR and RESP. REQ is ignored while BUSY, including a REQ raised
//   in the DONE cycle. Back-to-back requests are therefore at least 2 cycles apart.
//  Reset mid-operation: return to IDLE next edge. A pending RMW write is dropped, so memory
//   keeps its old word. No DONE is issued.
//  The memory sees at most one of M_REN or M_WEN per cycle; no same-cycle R/W collision.
// CONFIGURATION
//  Macro DTCM_LSU_MISALIGN_CHK_EN:
//   defined:   H/HU with ADDR[0]=1, or W with ADDR[1:0]!=0, take the invalid-FUNCT3 path
//              (no access, DONE+ERR).
//   undefined: misaligned low bits are forced to alignment (H: ADDR[0]=0; W: ADDR[1:0]=0);
//              ERR is raised only for invalid FUNCT3.
// STRUCTURE
//  Shared header dtcm_lsu_defs.vh: FUNCT3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU),
//   FSM state encodings, lane-select helpers.
//  Sub-module lsu_lane_align (combinational): load-lane extract + extend, store-lane merge.
//   Instantiated once for the load path and once for the merge path.
// TESTING
//  1 SW 0x11223344 @0x04, then LW @0x04 -> RDATA=0x11223344; DONE at acceptance+1 and +2.
//  2 SB WDATA=0xAA @0x06 over 0x11223344 -> word @0x04 reads 0x11AA3344; M_WEN asserted
//    exactly 1 cycle.
//  3 Word @0x08 = 0x00008080: LB @0x08 -> 0xFFFFFF80; LBU -> 0x00000080;
//    LH @0x08 -> 0xFFFF8080; LHU -> 0x00008080.
//  4 LH @0x03 with macro -> DONE+ERR, M_REN/M_WEN stay 0.
//    Without macro -> reads the half at 0x02, no ERR.
//  5 SH 0xBEEF @0x0A, RST high in the RMW_WR cycle -> word unchanged, no DONE,
//    BUSY=0 after the edge.
//  6 FUNCT3=3'b111 load -> DONE+ERR one cycle later, RDATA unchanged.
//    REQ held through DONE -> re-accepted only in the next IDLE cycle.

Source files
------------

// File: rtl/dtcm_lsu_pkg.sv
// dtcm_lsu_pkg
//   Shared definitions for the DTCM load/store unit: RV32I load/store FUNCT3
//   codes, FSM state encodings and small lane/size helper functions.
//   No ports. Imported by dtcm_lsu and dtcm_lsu_lane_align.
//   Optional feature macro used by the top: DTCM_LSU_MISALIGN_CHK_EN.
package dtcm_lsu_pkg;

    typedef logic [2:0] funct3_t;

    localparam funct3_t F3_B  = 3'b000;
    localparam funct3_t F3_H  = 3'b001;
    localparam funct3_t F3_W  = 3'b010;
    localparam funct3_t F3_BU = 3'b100;
    localparam funct3_t F3_HU = 3'b101;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LD_WAIT = 2'd1;
    localparam logic [1:0] ST_RMW_WR  = 2'd2;
    localparam logic [1:0] ST_RESP    = 2'd3;

    function automatic logic f3_is_valid(input funct3_t f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // Word accesses need no read-modify-write; everything else is sub-word.
    function automatic logic f3_is_word(input funct3_t f3);
        return f3[1:0] == 2'b10;
    endfunction

    function automatic logic f3_misaligned(input funct3_t f3, input logic [1:0] off);
        logic mis;
        case (f3)
            F3_H, F3_HU: mis = off[0];
            F3_W:        mis = (off != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Forces the byte offset onto the natural boundary of the access size.
    function automatic logic [1:0] align_off(input funct3_t f3, input logic [1:0] off);
        logic [1:0] res;
        case (f3)
            F3_H, F3_HU: res = {off[1], 1'b0};
            F3_W:        res = 2'b00;
            default:     res = off;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dtcm_lsu_if.sv
// dtcm_lsu_if
//   Bundles the core-side request/response handshake and the 1R1W memory
//   port of the DTCM load/store unit.
//   Core side : req, we, funct3, addr, wdata -> LSU ; busy, done, err, rdata <- LSU
//   Memory side: m_waddr, m_wdata, m_wen, m_raddr, m_ren <- LSU ; m_rdata -> LSU
//   Modports: slave  = the LSU itself
//             master = its environment (core MEM stage plus the memory array)
interface dtcm_lsu_if #(
    parameter int AW = 4,
    parameter int DW = 32
);
    logic          req;
    logic          we;
    logic [2:0]    funct3;
    logic [31:0]   addr;
    logic [DW-1:0] wdata;
    logic          busy;
    logic          done;
    logic          err;
    logic [DW-1:0] rdata;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    logic          m_wen;
    logic [AW-1:0] m_raddr;
    logic          m_ren;
    logic [DW-1:0] m_rdata;

    modport slave (
        input  req, we, funct3, addr, wdata, m_rdata,
        output busy, done, err, rdata,
        output m_waddr, m_wdata, m_wen, m_raddr, m_ren
    );

    modport master (
        output req, we, funct3, addr, wdata, m_rdata,
        input  busy, done, err, rdata,
        input  m_waddr, m_wdata, m_wen, m_raddr, m_ren
    );
endinterface

// File: rtl/dtcm_lsu_lane_align.sv
// dtcm_lsu_lane_align
//   Combinational byte/half lane handling for the LSU.
//   MERGE=0: extract the lane selected by off from word and sign/zero extend
//            it according to funct3 (word loads pass through).
//   MERGE=1: return word with the lane selected by off replaced by the
//            right-aligned bytes of sdata (word stores return sdata).
//   Ports: funct3 (access type), off (byte offset), word (memory word),
//          sdata (store data), result (extended load or merged word).
module dtcm_lsu_lane_align
    import dtcm_lsu_pkg::*;
#(
    parameter int DW    = 32,
    parameter bit MERGE = 1'b0
) (
    input  logic [2:0]    funct3,
    input  logic [1:0]    off,
    input  logic [DW-1:0] word,
    input  logic [DW-1:0] sdata,
    output logic [DW-1:0] result
);

    logic [7:0]    lane_b;
    logic [15:0]   lane_h;
    logic [DW-1:0] ext;
    logic [DW-1:0] merged;

    always_comb begin
        case (off)
            2'd0:    lane_b = word[7:0];
            2'd1:    lane_b = word[15:8];
            2'd2:    lane_b = word[23:16];
            default: lane_b = word[31:24];
        endcase
        lane_h = off[1] ? word[31:16] : word[15:0];

        case (funct3)
            F3_B:    ext = {{24{lane_b[7]}}, lane_b};
            F3_BU:   ext = {24'b0, lane_b};
            F3_H:    ext = {{16{lane_h[15]}}, lane_h};
            F3_HU:   ext = {16'b0, lane_h};
            default: ext = word;
        endcase

        merged = word;
        case (funct3[1:0])
            2'b00: begin
                case (off)
                    2'd0:    merged[7:0]   = sdata[7:0];
                    2'd1:    merged[15:8]  = sdata[7:0];
                    2'd2:    merged[23:16] = sdata[7:0];
                    default: merged[31:24] = sdata[7:0];
                endcase
            end
            2'b01: begin
                if (off[1]) merged[31:16] = sdata[15:0];
                else        merged[15:0]  = sdata[15:0];
            end
            default: merged = sdata;
        endcase

        result = MERGE ? merged : ext;
    end

endmodule

// File: rtl/dtcm_lsu.sv
// dtcm_lsu
//   Load/store unit in front of a 1R1W word-wide data memory. Handles one
//   request at a time; sub-word stores are done as read-modify-write since
//   the memory has no byte enables. Loads are extended per RV32I funct3.
//   Ports: clk, rst (synchronous, active high)
//          bus (dtcm_lsu_if.slave): core request/response and memory port.
//   Optional macro DTCM_LSU_MISALIGN_CHK_EN: when defined, misaligned H/HU/W
//   requests are rejected with done+err; otherwise the low address bits are
//   forced to alignment.
//
//   state    | meaning
//   IDLE     | waiting for req; memory port driven from the live request
//   LD_WAIT  | load read in flight; extend and register rdata at the end
//   RMW_WR   | old word back from memory; write merged word
//   RESP     | done (and err for rejected requests) this cycle
module dtcm_lsu
    import dtcm_lsu_pkg::*;
#(
    parameter int AW = 4,
    parameter int DW = 32
) (
    input  logic       clk,
    input  logic       rst,
    dtcm_lsu_if.slave  bus
);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [2:0]    lat_f3;
    logic [AW-1:0] lat_waddr;
    logic [1:0]    lat_off;
    logic [DW-1:0] lat_wdata;
    logic          done_q;
    logic          err_q;
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] ld_ext;
    logic [DW-1:0] st_merged;

    logic          req_ok;
    logic          accept;
    logic [AW-1:0] req_waddr;
    logic [1:0]    req_off;

    logic          m_ren_c;
    logic          m_wen_c;
    logic [AW-1:0] m_raddr_c;
    logic [AW-1:0] m_waddr_c;
    logic [DW-1:0] m_wdata_c;

    logic          unused_addr_hi;
    assign unused_addr_hi = ^bus.addr[31:AW+2];

`ifdef DTCM_LSU_MISALIGN_CHK_EN
    assign req_ok = f3_is_valid(bus.funct3) && !f3_misaligned(bus.funct3, bus.addr[1:0]);
`else
    assign req_ok = f3_is_valid(bus.funct3);
`endif

    // A load finishes with done raised in IDLE; a request seen in that
    // cycle is still ignored so back-to-back requests stay 2 cycles apart.
    assign accept    = (state == ST_IDLE) && bus.req && !done_q;
    assign req_waddr = bus.addr[AW+1:2];
    assign req_off   = align_off(bus.funct3, bus.addr[1:0]);

    always_comb begin
        state_nxt = state;
        m_ren_c   = 1'b0;
        m_wen_c   = 1'b0;
        m_raddr_c = lat_waddr;
        m_waddr_c = lat_waddr;
        m_wdata_c = lat_wdata;
        case (state)
            ST_IDLE: begin
                m_raddr_c = req_waddr;
                m_waddr_c = req_waddr;
                m_wdata_c = bus.wdata;
                if (accept) begin
                    if (!req_ok) begin
                        state_nxt = ST_RESP;
                    end else if (!bus.we) begin
                        m_ren_c   = 1'b1;
                        state_nxt = ST_LD_WAIT;
                    end else if (!f3_is_word(bus.funct3)) begin
                        m_ren_c   = 1'b1;
                        state_nxt = ST_RMW_WR;
                    end else begin
                        m_wen_c   = 1'b1;
                        state_nxt = ST_RESP;
                    end
                end
            end
            ST_LD_WAIT: state_nxt = ST_IDLE;
            ST_RMW_WR: begin
                m_wen_c   = 1'b1;
                m_wdata_c = st_merged;
                state_nxt = ST_RESP;
            end
            ST_RESP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Gating by rst also drops an RMW write caught by a mid-operation reset.
    assign bus.m_ren   = m_ren_c & ~rst;
    assign bus.m_wen   = m_wen_c & ~rst;
    assign bus.m_raddr = m_raddr_c;
    assign bus.m_waddr = m_waddr_c;
    assign bus.m_wdata = m_wdata_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            lat_f3    <= '0;
            lat_waddr <= '0;
            lat_off   <= '0;
            lat_wdata <= '0;
        end else begin
            state  <= state_nxt;
            done_q <= (state == ST_LD_WAIT) || (state_nxt == ST_RESP);
            err_q  <= accept && !req_ok;
            if (state == ST_LD_WAIT) begin
                rdata_q <= ld_ext;
            end
            if (accept) begin
                lat_f3    <= bus.funct3;
                lat_waddr <= req_waddr;
                lat_off   <= req_off;
                lat_wdata <= bus.wdata;
            end
        end
    end

    dtcm_lsu_lane_align #(.DW(DW), .MERGE(1'b0)) u_load_align (
        .funct3 (lat_f3),
        .off    (lat_off),
        .word   (bus.m_rdata),
        .sdata  ('0),
        .result (ld_ext)
    );

    dtcm_lsu_lane_align #(.DW(DW), .MERGE(1'b1)) u_merge_align (
        .funct3 (lat_f3),
        .off    (lat_off),
        .word   (bus.m_rdata),
        .sdata  (lat_wdata),
        .result (st_merged)
    );

    assign bus.busy  = (state != ST_IDLE);
    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_dtcm_lsu.sv
// tb_dtcm_lsu
//   Directed bench for dtcm_lsu with a behavioural 16-word 1R1W memory
//   (write at the clock edge, read data registered one cycle after m_ren).
//   Inputs are driven and outputs sampled on the falling edge.
//   Honours DTCM_LSU_MISALIGN_CHK_EN for the misalignment expectations.
module tb_dtcm_lsu;
    import dtcm_lsu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    dtcm_lsu_if #(.AW(4), .DW(32)) bus ();

    dtcm_lsu #(.AW(4), .DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:15];
    int          wen_cnt = 0;
    int          ren_cnt = 0;
    logic        collide = 1'b0;

    always @(posedge clk) begin
        if (bus.m_wen) begin
            mem[bus.m_waddr] <= bus.m_wdata;
            wen_cnt <= wen_cnt + 1;
        end
        if (bus.m_ren) begin
            bus.m_rdata <= mem[bus.m_raddr];
            ren_cnt <= ren_cnt + 1;
        end
        if (bus.m_wen && bus.m_ren) collide <= 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge with the LSU idle. Holds req until
    // done, then spends one more idle cycle so the next call is accepted at once.
    task automatic run_req(input logic w, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] d, output int lat, output logic e,
                           output logic [31:0] rd);
        bus.req = 1'b1; bus.we = w; bus.funct3 = f; bus.addr = a; bus.wdata = d;
        lat = -1; e = 1'b0; rd = '0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = i; e = bus.err; rd = bus.rdata;
                break;
            end
        end
        bus.req = 1'b0;
        @(negedge clk);
    endtask

    int          lat;
    logic        e;
    logic [31:0] rd;
    int          w0, r0;

    initial begin
        bus.req = 1'b1; bus.we = 1'b0; bus.funct3 = F3_W; bus.addr = 32'h4; bus.wdata = '0;
        @(posedge clk); @(posedge clk);
        @(negedge clk); #1;
        chk("rst_m_ren", {31'b0, bus.m_ren}, 32'd0);
        chk("rst_m_wen", {31'b0, bus.m_wen}, 32'd0);
        chk("rst_busy",  {31'b0, bus.busy},  32'd0);
        chk("rst_done",  {31'b0, bus.done},  32'd0);
        chk("rst_err",   {31'b0, bus.err},   32'd0);
        chk("rst_rdata", bus.rdata, 32'h0);
        bus.req = 1'b0; rst = 1'b0;
        @(negedge clk);

        // SW then LW
        w0 = wen_cnt; r0 = ren_cnt;
        run_req(1'b1, F3_W, 32'h04, 32'h11223344, lat, e, rd);
        chk("sw_lat", 32'(lat), 32'd1);
        chk("sw_err", {31'b0, e}, 32'd0);
        chk("sw_wen_cnt", 32'(wen_cnt - w0), 32'd1);
        chk("sw_ren_cnt", 32'(ren_cnt - r0), 32'd0);
        run_req(1'b0, F3_W, 32'h04, 32'h0, lat, e, rd);
        chk("lw_lat", 32'(lat), 32'd2);
        chk("lw_rdata", rd, 32'h11223344);

        // SB via read-modify-write
        w0 = wen_cnt; r0 = ren_cnt;
        run_req(1'b1, F3_B, 32'h06, 32'h000000AA, lat, e, rd);
        chk("sb_lat", 32'(lat), 32'd2);
        chk("sb_wen_cnt", 32'(wen_cnt - w0), 32'd1);
        chk("sb_ren_cnt", 32'(ren_cnt - r0), 32'd1);
        run_req(1'b0, F3_W, 32'h04, 32'h0, lat, e, rd);
        chk("sb_readback", rd, 32'h11AA3344);

        // Extension
        run_req(1'b1, F3_W, 32'h08, 32'h00008080, lat, e, rd);
        run_req(1'b0, F3_B, 32'h08, 32'h0, lat, e, rd);
        chk("lb", rd, 32'hFFFFFF80);
        run_req(1'b0, F3_BU, 32'h08, 32'h0, lat, e, rd);
        chk("lbu", rd, 32'h00000080);
        run_req(1'b0, F3_H, 32'h08, 32'h0, lat, e, rd);
        chk("lh", rd, 32'hFFFF8080);
        run_req(1'b0, F3_HU, 32'h08, 32'h0, lat, e, rd);
        chk("lhu", rd, 32'h00008080);
        run_req(1'b0, F3_B, 32'h09, 32'h0, lat, e, rd);
        chk("lb_off1", rd, 32'hFFFFFF80);
        run_req(1'b1, F3_H, 32'h0A, 32'h0000BEEF, lat, e, rd);
        run_req(1'b0, F3_W, 32'h08, 32'h0, lat, e, rd);
        chk("sh_readback", rd, 32'hBEEF8080);

        // Misaligned accesses
        run_req(1'b1, F3_W, 32'h00, 32'hCAFE1234, lat, e, rd);
        w0 = wen_cnt; r0 = ren_cnt;
        run_req(1'b0, F3_H, 32'h03, 32'h0, lat, e, rd);
`ifdef DTCM_LSU_MISALIGN_CHK_EN
        chk("lh_mis_lat", 32'(lat), 32'd1);
        chk("lh_mis_err", {31'b0, e}, 32'd1);
        chk("lh_mis_ren", 32'(ren_cnt - r0), 32'd0);
        chk("lh_mis_wen", 32'(wen_cnt - w0), 32'd0);
        run_req(1'b0, F3_W, 32'h05, 32'h0, lat, e, rd);
        chk("lw_mis_err", {31'b0, e}, 32'd1);
`else
        chk("lh_mis_lat", 32'(lat), 32'd2);
        chk("lh_mis_err", {31'b0, e}, 32'd0);
        chk("lh_mis_rdata", rd, 32'hFFFFCAFE);
        run_req(1'b0, F3_W, 32'h05, 32'h0, lat, e, rd);
        chk("lw_mis_rdata", rd, 32'h11AA3344);
`endif
        run_req(1'b0, F3_W, 32'h08, 32'h0, lat, e, rd);
        chk("pre_rst_word", rd, 32'hBEEF8080);

        // Reset during RMW_WR drops the write
        w0 = wen_cnt;
        bus.req = 1'b1; bus.we = 1'b1; bus.funct3 = F3_H; bus.addr = 32'h0A; bus.wdata = 32'h1234;
        #1;
        chk("rmw_rd_ren", {31'b0, bus.m_ren}, 32'd1);
        @(negedge clk); #1;
        chk("rmw_wr_wen", {31'b0, bus.m_wen}, 32'd1);
        chk("rmw_wr_busy", {31'b0, bus.busy}, 32'd1);
        rst = 1'b1; bus.req = 1'b0;
        #1;
        chk("rmw_rst_wen", {31'b0, bus.m_wen}, 32'd0);
        @(negedge clk);
        chk("rmw_rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rmw_rst_done", {31'b0, bus.done}, 32'd0);
        chk("rmw_rst_wcnt", 32'(wen_cnt - w0), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        run_req(1'b0, F3_W, 32'h08, 32'h0, lat, e, rd);
        chk("rmw_rst_word", rd, 32'hBEEF8080);

        // Invalid funct3 with req held through done
        bus.req = 1'b1; bus.we = 1'b0; bus.funct3 = 3'b111; bus.addr = 32'h04;
        #1;
        chk("inv_m_ren", {31'b0, bus.m_ren}, 32'd0);
        chk("inv_m_wen", {31'b0, bus.m_wen}, 32'd0);
        @(negedge clk);
        chk("inv_done", {31'b0, bus.done}, 32'd1);
        chk("inv_err",  {31'b0, bus.err},  32'd1);
        chk("inv_busy", {31'b0, bus.busy}, 32'd1);
        chk("inv_rdata", bus.rdata, 32'hBEEF8080);
        @(negedge clk);
        chk("inv_gap_done", {31'b0, bus.done}, 32'd0);
        chk("inv_gap_busy", {31'b0, bus.busy}, 32'd0);
        @(negedge clk);
        chk("inv_re_done", {31'b0, bus.done}, 32'd1);
        chk("inv_re_err",  {31'b0, bus.err},  32'd1);
        bus.req = 1'b0;
        @(negedge clk);

        // Load with req held: ignored in its done cycle, re-accepted next cycle
        bus.req = 1'b1; bus.we = 1'b0; bus.funct3 = F3_W; bus.addr = 32'h04;
        @(negedge clk);
        chk("ldh_busy", {31'b0, bus.busy}, 32'd1);
        @(negedge clk); #1;
        chk("ldh_done", {31'b0, bus.done}, 32'd1);
        chk("ldh_done_busy", {31'b0, bus.busy}, 32'd0);
        chk("ldh_done_ren", {31'b0, bus.m_ren}, 32'd0);
        @(negedge clk); #1;
        chk("ldh_next_done", {31'b0, bus.done}, 32'd0);
        chk("ldh_next_ren", {31'b0, bus.m_ren}, 32'd1);
        @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
        chk("ldh2_done", {31'b0, bus.done}, 32'd1);
        chk("ldh2_rdata", bus.rdata, 32'h11AA3344);
        @(negedge clk);

        chk("no_collision", {31'b0, collide}, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
